// File: rtl/timer_bank_if.sv
// Configuration write bus for timer_bank: one channel's duration, irq enable
// and mode are written per cfg_enable strobe.
interface timer_bank_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic             cfg_enable;
   logic [CH_W-1:0]  cfg_chan;
   logic [WIDTH-1:0] cfg_time_ms;
   logic             cfg_irq_en;
   logic             cfg_periodic;

   modport master (
      output cfg_enable, cfg_chan, cfg_time_ms, cfg_irq_en, cfg_periodic
   );

   modport slave (
      input cfg_enable, cfg_chan, cfg_time_ms, cfg_irq_en, cfg_periodic
   );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: CHANNELS independent millisecond down-counters sharing one
// free-running prescaler. Each channel has a sticky done flag and a sticky
// pending flag; pending bits are ORed into one interrupt line and the lowest
// pending index is reported on irq_chan.
// Optional feature macro: TIMER_BANK_PERIODIC_EN (auto-reload on expiry).
// Without it every channel is one-shot and cfg_periodic is ignored.
module timer_bank #(
   parameter int TICK_DIV = 27000,
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   timer_bank_if.slave         cfg,
   input  logic [CHANNELS-1:0] start,
   input  logic [CHANNELS-1:0] stop,
   input  logic [CHANNELS-1:0] clear_mask,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done,
   output logic [CHANNELS-1:0] pending,
   output logic                interrupt,
   output logic [CH_W-1:0]     irq_chan
);
   localparam int PW = $clog2(TICK_DIV);

   logic [PW-1:0]       presc_reg;
   logic                tick;
   logic [CHANNELS-1:0] busy_reg, done_reg, pending_reg;
   logic [CHANNELS-1:0] busy_next, done_next, pending_next, set_vec;
   logic                interrupt_reg;
   logic [CH_W-1:0]     irq_chan_reg, irq_chan_next;

`ifndef TIMER_BANK_PERIODIC_EN
   logic unused_periodic;
   assign unused_periodic = cfg.cfg_periodic;
`endif

   // Tick is the cycle whose edge wraps the prescaler back to 0.
   assign tick = (presc_reg == PW'(TICK_DIV - 1));

   // Free-running prescaler; start pulses never touch it.
   always_ff @(posedge clk) begin
      if (rst || tick) presc_reg <= '0;
      else             presc_reg <= presc_reg + 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [WIDTH-1:0] time_reg, count_reg, count_next, time_eff;
         logic             irq_en_reg, irq_eff, wr, reload;
         logic             ch_busy, ch_done, ch_set;

         // Writes aimed at an index outside the bank never match any channel.
         assign wr       = cfg.cfg_enable && (cfg.cfg_chan == CH_W'(gi));
         // A start in the same cycle as a cfg write uses the new values.
         assign time_eff = wr ? cfg.cfg_time_ms : time_reg;
         assign irq_eff  = wr ? cfg.cfg_irq_en  : irq_en_reg;

`ifdef TIMER_BANK_PERIODIC_EN
         logic periodic_reg;
         // Mode register, consulted only at expiry.
         always_ff @(posedge clk) begin
            if (rst)     periodic_reg <= 1'b0;
            else if (wr) periodic_reg <= cfg.cfg_periodic;
         end
         assign reload = periodic_reg;
`else
         assign reload = 1'b0;
`endif

         // Channel configuration registers; a write never disturbs count_reg.
         always_ff @(posedge clk) begin
            if (rst) begin
               time_reg   <= '0;
               irq_en_reg <= 1'b0;
            end else if (wr) begin
               time_reg   <= cfg.cfg_time_ms;
               irq_en_reg <= cfg.cfg_irq_en;
            end
         end

         // Event priority: start, then stop, then tick/expiry.
         always_comb begin
            count_next = count_reg;
            ch_busy    = busy_reg[gi];
            ch_done    = done_reg[gi];
            ch_set     = 1'b0;
            if (start[gi]) begin
               if (time_eff == '0) begin
                  count_next = '0;
                  ch_busy    = 1'b0;
                  ch_done    = 1'b1;
                  ch_set     = irq_eff;
               end else begin
                  count_next = time_eff;
                  ch_busy    = 1'b1;
                  ch_done    = 1'b0;
               end
            end else if (stop[gi]) begin
               ch_busy = 1'b0;
               ch_done = 1'b0;
            end else if (tick && busy_reg[gi]) begin
               if (count_reg <= WIDTH'(1)) begin
                  ch_done = 1'b1;
                  ch_set  = irq_en_reg;
                  if (reload) count_next = time_reg;
                  else        ch_busy    = 1'b0;
               end else begin
                  count_next = count_reg - WIDTH'(1);
               end
            end
         end

         // Remaining-ms counter.
         always_ff @(posedge clk) begin
            if (rst) count_reg <= '0;
            else     count_reg <= count_next;
         end

         assign busy_next[gi] = ch_busy;
         assign done_next[gi] = ch_done;
         assign set_vec[gi]   = ch_set;
      end
   endgenerate

   // Sticky pending (set beats clear) and lowest-index priority encode.
   always_comb begin
      pending_next  = (pending_reg & ~clear_mask) | set_vec;
      irq_chan_next = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (pending_next[i]) irq_chan_next = CH_W'(i);
      end
   end

   // Status registers; interrupt/irq_chan are built from pending_next so they
   // change in the same cycle as pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_reg      <= '0;
         done_reg      <= '0;
         pending_reg   <= '0;
         interrupt_reg <= 1'b0;
         irq_chan_reg  <= '0;
      end else begin
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         pending_reg   <= pending_next;
         interrupt_reg <= |pending_next;
         irq_chan_reg  <= irq_chan_next;
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign pending   = pending_reg;
   assign interrupt = interrupt_reg;
   assign irq_chan  = irq_chan_reg;
endmodule

// File: tb/tb_timer_bank.sv
// Testbench for timer_bank: a tick-level behavioural model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_timer_bank;
   localparam int TD = 4;
   localparam int NC = 4;
   localparam int W  = 16;
   localparam int CW = 2;
`ifdef TIMER_BANK_PERIODIC_EN
   localparam bit PER_EN = 1'b1;
`else
   localparam bit PER_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NC-1:0] start = '0, stop = '0, clear_mask = '0;
   logic [NC-1:0] busy, done, pending;
   logic          interrupt;
   logic [CW-1:0] irq_chan;

   timer_bank_if #(.CHANNELS(NC), .WIDTH(W)) cfg_if ();

   timer_bank #(.TICK_DIV(TD), .CHANNELS(NC), .WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg        (cfg_if),
      .start      (start),
      .stop       (stop),
      .clear_mask (clear_mask),
      .busy       (busy),
      .done       (done),
      .pending    (pending),
      .interrupt  (interrupt),
      .irq_chan   (irq_chan)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_cyc;
   int          m_time [NC];
   bit          m_irq  [NC];
   bit          m_per  [NC];
   int          m_rem  [NC];
   bit [NC-1:0] m_busy, m_done, m_pend;

   always @(posedge clk) begin
      bit          tk;
      bit          wr;
      bit          ir;
      int          t;
      int          exp_chan;
      bit [NC-1:0] setv;
      if (rst) begin
         m_cyc  = 0;
         m_busy = '0;
         m_done = '0;
         m_pend = '0;
         for (int i = 0; i < NC; i++) begin
            m_time[i] = 0; m_irq[i] = 0; m_per[i] = 0; m_rem[i] = 0;
         end
      end else begin
         // one tick every TD cycles, the first TD cycles after reset
         tk    = ((m_cyc + 1) % TD) == 0;
         m_cyc = (m_cyc + 1) % TD;
         setv  = '0;
         for (int i = 0; i < NC; i++) begin
            wr = cfg_if.cfg_enable && (int'(cfg_if.cfg_chan) == i);
            t  = wr ? int'(cfg_if.cfg_time_ms) : m_time[i];
            ir = wr ? cfg_if.cfg_irq_en : m_irq[i];
            if (start[i]) begin
               if (t == 0) begin
                  m_busy[i] = 0; m_done[i] = 1; setv[i] = ir;
               end else begin
                  m_rem[i] = t; m_busy[i] = 1; m_done[i] = 0;
               end
            end else if (stop[i]) begin
               m_busy[i] = 0; m_done[i] = 0;
            end else if (tk && m_busy[i]) begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] <= 0) begin
                  m_done[i] = 1;
                  setv[i]   = m_irq[i];
                  if (PER_EN && m_per[i]) m_rem[i] = m_time[i];
                  else                    m_busy[i] = 0;
               end
            end
            if (wr) begin
               m_time[i] = int'(cfg_if.cfg_time_ms);
               m_irq[i]  = cfg_if.cfg_irq_en;
               m_per[i]  = cfg_if.cfg_periodic;
            end
         end
         m_pend = (m_pend & ~clear_mask) | setv;
      end
      exp_chan = 0;
      for (int i = NC - 1; i >= 0; i--) if (m_pend[i]) exp_chan = i;
      #1;
      chk("busy",      busy,      m_busy);
      chk("done",      done,      m_done);
      chk("pending",   pending,   m_pend);
      chk("interrupt", interrupt, |m_pend);
      chk("irq_chan",  irq_chan,  exp_chan);
   end

   // ---------------- stimulus helpers ----------------
   task automatic next();
      @(negedge clk);
      start = '0; stop = '0; clear_mask = '0;
      cfg_if.cfg_enable = 1'b0;
   endtask

   task automatic set_cfg(input int ch, input int t, input bit irq, input bit per);
      cfg_if.cfg_enable   = 1'b1;
      cfg_if.cfg_chan     = CW'(ch);
      cfg_if.cfg_time_ms  = W'(t);
      cfg_if.cfg_irq_en   = irq;
      cfg_if.cfg_periodic = per;
   endtask

   initial begin
      int n;
      int cnt;
      cfg_if.cfg_enable = 0; cfg_if.cfg_chan = '0; cfg_if.cfg_time_ms = '0;
      cfg_if.cfg_irq_en = 0; cfg_if.cfg_periodic = 0;

      // 1: reset with a start pulse inside it
      @(negedge clk); start = 4'b0001;
      @(negedge clk); start = '0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pending", pending, 0);
      chk("rst_irq", {interrupt, 2'b00, irq_chan}, 0);
      rst = 1'b0;
      $display("test1 reset done");

      // 2: ch0 one-shot 3 ms with bypass cfg
      set_cfg(0, 3, 1, 0); start = 4'b0001; next();
      n = 0;
      while (busy[0] && n < 40) begin n++; next(); end
      $display("test2 busy_cycles=%0d", n);
      chk("t2_busy_len_in_9_12", (n >= 9 && n <= 12), 1);
      chk("t2_done", done[0], 1);
      chk("t2_pending", pending, 4'b0001);
      chk("t2_interrupt", interrupt, 1);
      chk("t2_irq_chan", irq_chan, 0);
      clear_mask = 4'b0001; next();
      chk("t2_clr_pending", pending, 0);
      chk("t2_clr_done", done[0], 1);
      chk("t2_clr_interrupt", interrupt, 0);

      // 3: ch1 periodic 2 ms, clearing between expiries
      set_cfg(1, 2, 1, 1); start = 4'b0010; next();
      cnt = 0;
      for (int k = 0; k < 32; k++) begin
         if (pending[1]) begin cnt++; clear_mask = 4'b0010; end
         next();
      end
      $display("test3 expiries=%0d busy1=%0b", cnt, busy[1]);
      if (PER_EN) begin
         chk("t3_expiries", (cnt >= 3 && cnt <= 4), 1);
         chk("t3_busy", busy[1], 1);
      end else begin
         chk("t3_expiries", cnt, 1);
         chk("t3_busy", busy[1], 0);
      end
      stop = 4'b0010; clear_mask = 4'b1111; next();

      // 4: ch2 and ch3 expire together
      set_cfg(2, 2, 1, 0); next();
      set_cfg(3, 2, 1, 0); next();
      start = 4'b1100; next();
      n = 0;
      while (!pending[2] && n < 20) begin n++; next(); end
      chk("t4_pending", pending, 4'b1100);
      chk("t4_irq_chan", irq_chan, 2);
      clear_mask = 4'b0100; next();
      chk("t4_irq_chan_after", irq_chan, 3);
      chk("t4_pending_after", pending, 4'b1000);
      start = 4'b0100; next();
      n = 0;
      while (!done[2] && n < 20) begin clear_mask = 4'b0100; n++; next(); end
      chk("t4_set_beats_clear", pending[2], 1);
      $display("test4 pending=%b", pending);
      clear_mask = 4'b1111; next();

      // 5: stop, start+stop, zero duration
      set_cfg(0, 5, 1, 0); start = 4'b0001; next();
      repeat (9) next();
      stop = 4'b0001; next();
      chk("t5_stop_busy", busy[0], 0);
      chk("t5_stop_done", done[0], 0);
      chk("t5_stop_pend", pending[0], 0);
      start = 4'b0001; stop = 4'b0001; next();
      chk("t5_startstop_busy", busy[0], 1);
      set_cfg(0, 0, 1, 0); start = 4'b0001; next();
      chk("t5_zero_done", done[0], 1);
      chk("t5_zero_busy", busy[0], 0);
      chk("t5_zero_pend", pending[0], 1);
      $display("test5 done=%b busy=%b", done, busy);
      clear_mask = 4'b1111; next();

      // 6: cfg write to a running periodic channel
      set_cfg(1, 2, 1, 1); start = 4'b0010; next();
      set_cfg(1, 10, 1, 1); next();
      n = 1;
      while (!pending[1] && n < 20) begin n++; next(); end
      chk("t6_first_expiry_le_8", (n <= 8), 1);
      clear_mask = 4'b0010;
      if (PER_EN) begin
         n = 0;
         do begin next(); n++; end while (!pending[1] && n < 60);
         $display("test6 reload_interval=%0d", n);
         chk("t6_reload_interval", n, 40);
      end else begin
         next();
         chk("t6_oneshot_busy", busy[1], 0);
      end
      stop = 4'b1111; clear_mask = 4'b1111; next();

      // random traffic, all checked by the per-cycle model compare
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 7) == 0)
            set_cfg($urandom_range(0, NC - 1), $urandom_range(0, 6),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int i = 0; i < NC; i++) begin
            start[i]      = ($urandom_range(0, 15) == 0);
            stop[i]       = ($urandom_range(0, 31) == 0);
            clear_mask[i] = ($urandom_range(0, 7) == 0);
         end
         rst = ($urandom_range(0, 499) == 0);
         next();
         rst = 1'b0;
      end
      next();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
